nco_phase_accum: RTL and testbench
==================================

# nco_phase_accum

Programmable phase accumulator feeding the NCO sine lookup stage: each enabled cycle it advances a 32-bit phase by a frequency tuning word (FTW) and emits the top bits, plus a phase offset, as the 8-bit table index. It also supports a linear sawtooth frequency sweep (chirp). Configuration arrives over a valid/ready register-write port. The block sits directly upstream of `counter_8bit`'s table and replaces its free-running 8-bit counter.

## Interface
- `ACC_W`, 32, accumulator, FTW, offset, step and limit width
- `PHASE_W`, 8, output index width (table depth 2^PHASE_W)
- `clk`  input  1  sole clock, rising edge
- `rst`  input  1  asynchronous, active-low reset
- `en`  input  1  run enable; sampled every edge
- `sweep_en`  input  1  selects sweep mode while running
- `sync_clr`  input  1  synchronous accumulator clear
- `cfg_valid`  input  1  config write request
- `cfg_ready`  output  1  config write accept
- `cfg_sel`  input  2  0=FTW, 1=phase offset, 2=sweep step, 3=sweep limit
- `cfg_data`  input  ACC_W  write data
- `phase_out`  output  PHASE_W  table index
- `phase_valid`  output  1  phase_out is a live sample
- `wrap`  output  1  one-cycle pulse on accumulator overflow
- `sweep_wrap`  output  1  one-cycle pulse when sweep reloads base FTW

## Operation
- Registers: `acc`, `ftw` (live), `ftw_base`, `off`, `step`, `limit`. All reset to 0.
- States:
  - IDLE: acc held, `phase_valid`=0.
  - RUN: acc += ftw.
  - SWEEP: acc += ftw and ftw advances.
- Transitions, evaluated each edge:
  - `en`=0 → IDLE.
  - `en`=1 with `sweep_en`=0 → RUN.
  - `en`=1 with `sweep_en`=1 → SWEEP.
  - RUN↔SWEEP switches directly.
  - Leaving SWEEP leaves ftw at its current value.
- Per edge in RUN/SWEEP:
  - `phase_out` ← (acc + off)[ACC_W-1 -: PHASE_W], using pre-add acc; sum is modulo 2^ACC_W.
  - acc ← acc + ftw, modulo 2^ACC_W.
  - `wrap` ← carry-out of that add.
  - `phase_valid` ← 1.
- In IDLE: `phase_valid`, `wrap` and `sweep_wrap` ← 0; `phase_out` holds its last value.
- Sweep, per SWEEP edge, with n = ftw + step at ACC_W+1 bits:
  - If n > limit (unsigned, carry included): ftw ← ftw_base and `sweep_wrap` ← 1.
  - Otherwise: ftw ← n[ACC_W-1:0].
  - step=0 with ftw ≤ limit: ftw constant, never wraps.
  - ftw_base > limit: reload on every SWEEP edge.
- `sync_clr`: acc ← 0, overriding the add; `wrap` ← 0. `phase_out`/`phase_valid` update normally from the pre-clear acc. Acts in any state, including IDLE.
- Config handshake:
  - A write is accepted on an edge with `cfg_valid` & `cfg_ready`.
  - `cfg_ready` is registered and resets to 1. It drops to 0 for exactly the cycle after an accept, then returns to 1, so the maximum rate is one write per 2 cycles.
  - The written register updates on the accepting edge and is used from the next edge.
  - An FTW write sets both ftw_base and ftw. It has priority over the sweep update on the same edge.
- Reset asserted mid-operation: all registers return to reset values immediately, including `cfg_ready`=1 and state IDLE. A partial handshake is discarded.

## Timing
- Latency: `en` sampled 1 at edge k → state RUN after k. First `phase_valid`=1 after edge k+1, with index from acc as held at k.
- `en` sampled 0 at edge k → `phase_valid`=0 after k.
- `phase_out` → table index path is registered; no combinational path from any input to any output.
- `wrap` and `sweep_wrap` are aligned with the `phase_out` they accompany.

## Structure
- Package `nco_pkg`:
  - `ACC_W`/`PHASE_W` defaults.
  - State enum `nco_state_t` {IDLE, RUN, SWEEP}.
  - `cfg_sel` codes: `CFG_FTW`, `CFG_OFF`, `CFG_STEP`, `CFG_LIMIT`.
- Sub-module `nco_sweep_ctrl`: holds ftw/ftw_base/step/limit, performs the compare/reload and FTW-write priority, and outputs live ftw and `sweep_wrap`.
- Top-level module: FSM, accumulator, offset add, config handshake.

## Test plan
- Reset, FTW=0x01000000, `en`=1 → `phase_out` 0x00,0x01,0x02,… one per cycle, `wrap` never set within 255 cycles, then pulses with index 0xFF→0x00.
- FTW=0x80000000 → `phase_out` alternates 0x00/0x80; `wrap` pulses every second valid sample.
- FTW=0x01000000, offset=0x40000000 → sequence starts at 0x40. `sync_clr` mid-run → index restarts at 0x40 two samples later.
- Sweep: base=0x01000000, step=0x01000000, limit=0x04000000 → ftw 1,2,3,4,1,2… (×2^24); `sweep_wrap` pulses once per 4 SWEEP cycles; `en`=0 → `phase_valid`=0 next edge.
- Back-to-back `cfg_valid` held for 4 writes → accepts on every other edge; `cfg_ready` toggles 1,0,1,0; all four registers hold their written values.
- Assert `rst` mid-SWEEP → all outputs 0, `cfg_ready`=1 asynchronously; after release, idle until `en`.

Source files
------------

// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared widths, state encoding and config register codes for the NCO
package nco_pkg;

  localparam int NCO_ACC_W   = 32;
  localparam int NCO_PHASE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SWEEP = 2'd2
  } nco_state_t;

  localparam logic [1:0] CFG_FTW   = 2'd0;
  localparam logic [1:0] CFG_OFF   = 2'd1;
  localparam logic [1:0] CFG_STEP  = 2'd2;
  localparam logic [1:0] CFG_LIMIT = 2'd3;

endpackage

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - live tuning word with sawtooth chirp sweep and reload
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int ACC_W = NCO_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sweep_tick,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [ACC_W-1:0] wr_data,
  output logic [ACC_W-1:0] ftw,
  output logic             sweep_wrap
);

  logic [ACC_W-1:0] ftw_q, ftw_d;
  logic [ACC_W-1:0] ftw_base_q, ftw_base_d;
  logic [ACC_W-1:0] step_q, step_d;
  logic [ACC_W-1:0] limit_q, limit_d;
  logic             sweep_wrap_q, sweep_wrap_d;
  logic [ACC_W:0]   next_ftw;

  always_comb begin
    // Carry kept so an overflowing step always counts as exceeding the limit
    next_ftw     = {1'b0, ftw_q} + {1'b0, step_q};
    ftw_d        = ftw_q;
    ftw_base_d   = ftw_base_q;
    step_d       = step_q;
    limit_d      = limit_q;
    sweep_wrap_d = 1'b0;
    if (sweep_tick) begin
      if (next_ftw > {1'b0, limit_q}) begin
        ftw_d        = ftw_base_q;
        sweep_wrap_d = 1'b1;
      end else begin
        ftw_d = next_ftw[ACC_W-1:0];
      end
    end
    if (wr_en) begin
      case (wr_sel)
        CFG_FTW: begin
          ftw_base_d = wr_data;
          ftw_d      = wr_data;
        end
        CFG_STEP:  step_d  = wr_data;
        CFG_LIMIT: limit_d = wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ftw_q        <= '0;
      ftw_base_q   <= '0;
      step_q       <= '0;
      limit_q      <= '0;
      sweep_wrap_q <= 1'b0;
    end else begin
      ftw_q        <= ftw_d;
      ftw_base_q   <= ftw_base_d;
      step_q       <= step_d;
      limit_q      <= limit_d;
      sweep_wrap_q <= sweep_wrap_d;
    end
  end

  assign ftw        = ftw_q;
  assign sweep_wrap = sweep_wrap_q;

endmodule

// File: rtl/nco_phase_accum.sv
// rtl/nco_phase_accum.sv - phase accumulator producing the sine table index, with chirp sweep
module nco_phase_accum
  import nco_pkg::*;
#(
  parameter int ACC_W   = NCO_ACC_W,
  parameter int PHASE_W = NCO_PHASE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sweep_en,
  input  logic               sync_clr,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_sel,
  input  logic [ACC_W-1:0]   cfg_data,
  output logic [PHASE_W-1:0] phase_out,
  output logic               phase_valid,
  output logic               wrap,
  output logic               sweep_wrap
);

  nco_state_t         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   off_q, off_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic               ready_q, ready_d;
  logic               active;
  logic               cfg_accept;
  logic [ACC_W-1:0]   ftw;
  logic [ACC_W-1:0]   idx_sum;
  logic [ACC_W:0]     acc_sum;
  logic               unused_idx_bits;

  always_comb begin
    // A running state only advances while en is still high on this edge
    active     = en && (state_q != IDLE);
    cfg_accept = cfg_valid && ready_q;
    idx_sum    = acc_q + off_q;
    acc_sum    = {1'b0, acc_q} + {1'b0, ftw};

    state_d = IDLE;
    if (en) state_d = sweep_en ? SWEEP : RUN;

    acc_d   = acc_q;
    phase_d = phase_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (active) begin
      acc_d   = acc_sum[ACC_W-1:0];
      phase_d = idx_sum[ACC_W-1 -: PHASE_W];
      valid_d = 1'b1;
      wrap_d  = acc_sum[ACC_W];
    end
    if (sync_clr) begin
      acc_d  = '0;
      wrap_d = 1'b0;
    end

    off_d   = (cfg_accept && (cfg_sel == CFG_OFF)) ? cfg_data : off_q;
    ready_d = !cfg_accept;
  end

  assign unused_idx_bits = ^idx_sum[ACC_W-PHASE_W-1:0];

  nco_sweep_ctrl #(.ACC_W(ACC_W)) u_sweep (
    .clk        (clk),
    .rst        (rst),
    .sweep_tick (active && (state_q == SWEEP)),
    .wr_en      (cfg_accept),
    .wr_sel     (cfg_sel),
    .wr_data    (cfg_data),
    .ftw        (ftw),
    .sweep_wrap (sweep_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      off_q   <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      off_q   <= off_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      ready_q <= ready_d;
    end
  end

  assign phase_out   = phase_q;
  assign phase_valid = valid_q;
  assign wrap        = wrap_q;
  assign cfg_ready   = ready_q;

endmodule

// File: tb/tb_nco_phase_accum.sv
// tb/tb_nco_phase_accum.sv - directed bench with a cycle-level reference model of the NCO
module tb_nco_phase_accum;
  import nco_pkg::*;

  localparam int AW = 32;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          sweep_en = 1'b0;
  logic          sync_clr = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_sel = 2'd0;
  logic [AW-1:0] cfg_data = '0;
  logic          cfg_ready;
  logic [PW-1:0] phase_out;
  logic          phase_valid;
  logic          wrap;
  logic          sweep_wrap;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  logic [AW-1:0] m_acc = '0, m_ftw = '0, m_base = '0, m_off = '0, m_step = '0, m_limit = '0;
  int            m_mode = 0;
  logic [PW-1:0] e_po = '0;
  logic          e_pv = 1'b0, e_wr = 1'b0, e_sw = 1'b0, e_rdy = 1'b1;

  always #5 clk = ~clk;

  nco_phase_accum #(.ACC_W(AW), .PHASE_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sweep_en    (sweep_en),
    .sync_clr    (sync_clr),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .phase_out   (phase_out),
    .phase_valid (phase_valid),
    .wrap        (wrap),
    .sweep_wrap  (sweep_wrap)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Mode: 0 idle, 1 run, 2 sweep; outputs are what the rules say must appear after this edge
  always @(posedge clk or negedge rst) begin : model
    logic [AW:0]   s;
    logic [AW:0]   n;
    logic [AW-1:0] t;
    bit            acc_ok;
    if (!rst) begin
      m_acc = '0; m_ftw = '0; m_base = '0; m_off = '0; m_step = '0; m_limit = '0;
      m_mode = 0; e_po = '0; e_pv = 1'b0; e_wr = 1'b0; e_sw = 1'b0; e_rdy = 1'b1;
    end else begin
      e_pv = 1'b0; e_wr = 1'b0; e_sw = 1'b0;
      if (en && m_mode != 0) begin
        t    = m_acc + m_off;
        e_po = PW'(t >> (AW - PW));
        s    = {1'b0, m_acc} + {1'b0, m_ftw};
        m_acc = s[AW-1:0];
        e_wr = s[AW] && !sync_clr;
        e_pv = 1'b1;
        if (m_mode == 2) begin
          n = {1'b0, m_ftw} + {1'b0, m_step};
          if (n > {1'b0, m_limit}) begin
            m_ftw = m_base;
            e_sw  = 1'b1;
          end else begin
            m_ftw = n[AW-1:0];
          end
        end
      end
      if (sync_clr) m_acc = '0;
      acc_ok = cfg_valid && e_rdy;
      if (acc_ok) begin
        case (cfg_sel)
          2'd0: begin m_base = cfg_data; m_ftw = cfg_data; end
          2'd1: m_off = cfg_data;
          2'd2: m_step = cfg_data;
          default: m_limit = cfg_data;
        endcase
      end
      e_rdy  = !acc_ok;
      m_mode = !en ? 0 : (sweep_en ? 2 : 1);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("phase_out", phase_out, e_po);
      chk("phase_valid", phase_valid, e_pv);
      chk("wrap", wrap, e_wr);
      chk("sweep_wrap", sweep_wrap, e_sw);
      chk("cfg_ready", cfg_ready, e_rdy);
    end
  end

  task automatic write_cfg(input logic [1:0] sel, input logic [AW-1:0] data);
    int w = 0;
    @(negedge clk);
    while (!cfg_ready && w < 4) begin
      @(negedge clk);
      w++;
    end
    if (!cfg_ready) chk("cfg_ready_timeout", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_sel = sel; cfg_data = data;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int w = 0;
    while (!phase_valid && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk("valid_timeout", phase_valid, 1);
  endtask

  task automatic stop_and_clear();
    en = 1'b0; sweep_en = 1'b0;
    @(negedge clk);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
  endtask

  logic [7:0]    sw_po [9] = '{8'h00, 8'h01, 8'h03, 8'h06, 8'h0A, 8'h0B, 8'h0D, 8'h10, 8'h14};
  logic          sw_fl [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0]    bb_sel [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [AW-1:0] bb_dat [4] = '{32'h0010_0000, 32'h1234_5678, 32'h0000_ABCD, 32'h7FFF_FFFF};

  initial begin
    int wraps;
    int idx;
    repeat (2) @(negedge clk);
    chk("rst_phase_out", phase_out, 0);
    chk("rst_phase_valid", phase_valid, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b1;
    cmp_on = 1'b1;

    // Unit-step ramp through one full table wrap
    write_cfg(CFG_FTW, 32'h0100_0000);
    en = 1'b1;
    @(negedge clk);
    wait_valid();
    wraps = 0;
    for (int i = 0; i < 255; i++) begin
      if (i < 3) chk("t1_idx", phase_out, i);
      wraps += int'(wrap);
      @(negedge clk);
    end
    chk("t1_no_early_wrap", wraps, 0);
    chk("t1_idx_ff", phase_out, 8'hFF);
    chk("t1_wrap_at_ff", wrap, 1);
    @(negedge clk);
    chk("t1_idx_00", phase_out, 8'h00);
    chk("t1_wrap_clears", wrap, 0);
    stop_and_clear();

    // Half-rate tone
    write_cfg(CFG_FTW, 32'h8000_0000);
    en = 1'b1;
    @(negedge clk);
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      chk("t2_idx", phase_out, (i % 2 == 1) ? 8'h80 : 8'h00);
      chk("t2_wrap", wrap, (i % 2 == 1) ? 1 : 0);
      @(negedge clk);
    end
    stop_and_clear();

    // Phase offset and synchronous clear mid-run
    write_cfg(CFG_FTW, 32'h0100_0000);
    write_cfg(CFG_OFF, 32'h4000_0000);
    en = 1'b1;
    @(negedge clk);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      chk("t3_idx", phase_out, 8'h40 + i);
      @(negedge clk);
    end
    sync_clr = 1'b1;
    @(negedge clk);
    chk("t3_preclear_idx", phase_out, 8'h44);
    sync_clr = 1'b0;
    @(negedge clk);
    chk("t3_restart_idx", phase_out, 8'h40);
    @(negedge clk);
    chk("t3_restart_next", phase_out, 8'h41);
    stop_and_clear();
    write_cfg(CFG_OFF, 32'h0);

    // Chirp: ftw 1,2,3,4,1,... in units of 2^24
    write_cfg(CFG_FTW, 32'h0100_0000);
    write_cfg(CFG_STEP, 32'h0100_0000);
    write_cfg(CFG_LIMIT, 32'h0400_0000);
    en = 1'b1; sweep_en = 1'b1;
    @(negedge clk);
    wait_valid();
    for (int i = 0; i < 9; i++) begin
      chk("t4_idx", phase_out, sw_po[i]);
      chk("t4_sweep_wrap", sweep_wrap, sw_fl[i]);
      @(negedge clk);
    end
    en = 1'b0; sweep_en = 1'b0;
    @(negedge clk);
    chk("t4_valid_drops", phase_valid, 0);

    // Back-to-back config writes with cfg_valid held
    @(negedge clk);
    idx = 0;
    cfg_valid = 1'b1; cfg_sel = bb_sel[0]; cfg_data = bb_dat[0];
    for (int c = 0; c < 8; c++) begin
      chk("t5_cfg_ready", cfg_ready, (c % 2 == 0) ? 1 : 0);
      @(negedge clk);
      if (c % 2 == 0 && idx < 3) begin
        idx++;
        cfg_sel = bb_sel[idx]; cfg_data = bb_dat[idx];
      end
    end
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("t5_ftw_base", dut.u_sweep.ftw_base_q, 32'h0010_0000);
    chk("t5_ftw", dut.u_sweep.ftw_q, 32'h0010_0000);
    chk("t5_off", dut.off_q, 32'h1234_5678);
    chk("t5_step", dut.u_sweep.step_q, 32'h0000_ABCD);
    chk("t5_limit", dut.u_sweep.limit_q, 32'h7FFF_FFFF);

    // Asynchronous reset in the middle of a sweep
    en = 1'b1; sweep_en = 1'b1;
    repeat (40) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_phase_out", phase_out, 0);
    chk("t6_phase_valid", phase_valid, 0);
    chk("t6_wrap", wrap, 0);
    chk("t6_sweep_wrap", sweep_wrap, 0);
    chk("t6_cfg_ready", cfg_ready, 1);
    chk("t6_ftw", dut.u_sweep.ftw_q, 0);
    en = 1'b0; sweep_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_idle_after_reset", phase_valid, 0);
    end
    en = 1'b1;
    @(negedge clk);
    wait_valid();
    chk("t6_first_idx", phase_out, 0);
    en = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
